// File: rtl/dwg_pkg.sv
// dwg_pkg: shared definitions for the digital-waveguide delay line.
//   DW_DEFAULT  default sample width (18 bits)
//   sample_t    sample type at the default width
//   clr_state_t state of the optional memory-clear sweep
//   make_addr   packs {channel, pointer} into a flat RAM address
package dwg_pkg;

  localparam int DW_DEFAULT = 18;

  typedef logic [DW_DEFAULT-1:0] sample_t;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_SWEEP = 1'b1
  } clr_state_t;

  // The channel index forms the upper address bits and the per-channel pointer
  // the lower aw bits. The pointer is masked to aw bits, so modular pointer
  // arithmetic can be passed in unreduced.
  function automatic logic [31:0] make_addr(input logic [31:0] ch,
                                            input logic [31:0] ptr,
                                            input int          aw);
    logic [31:0] mask;
    mask = (32'd1 << aw) - 32'd1;
    return (ch << aw) | (ptr & mask);
  endfunction

endpackage

// File: rtl/dwg_sdp_ram.sv
// dwg_sdp_ram: simple dual-port RAM with one write port and one registered
// read port. Written so synthesis maps it onto block RAM.
//   clk    clock
//   we     write enable
//   waddr  write address (AW bits)
//   wdata  write data (DW bits)
//   re     read enable; rdata only updates when re=1
//   raddr  read address (AW bits)
//   rdata  registered read data (DW bits)
module dwg_sdp_ram #(
  parameter int DW = 18,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // Write and registered read share one clock; no reset so the array stays
  // a plain block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/dwg_delay_line.sv
// dwg_delay_line: multi-channel circular delay line for the waveguide voices.
// Each channel owns a write pointer; every accepted sample is written at the
// pointer and the sample in_len positions back is returned two cycles later.
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake
//   in_ch, in_len       channel and delay length (0 = bypass) of the sample
//   in_data             input sample
//   out_valid/out_ready output handshake
//   out_ch, out_data    channel and delayed sample
//   clr                 start a memory clear sweep (only with DL_CLEAR_EN)
// Optional feature macro: DL_CLEAR_EN adds the clr port and the clear FSM.
module dwg_delay_line
  import dwg_pkg::*;
#(
  parameter int DW  = DW_DEFAULT,
  parameter int AW  = 7,
  parameter int CHW = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [CHW-1:0] in_ch,
  input  logic [AW-1:0]  in_len,
  input  logic [DW-1:0]  in_data,
  output logic           out_valid,
  input  logic           out_ready,
`ifdef DL_CLEAR_EN
  input  logic           clr,
`endif
  output logic [CHW-1:0] out_ch,
  output logic [DW-1:0]  out_data
);

  localparam int NCH = 2**CHW;
  localparam int RAW = AW + CHW;

  logic           en;
  logic           acc;
  logic           byp;
  logic           busy;
  logic           wipe;
  logic [RAW-1:0] sweep;
  logic [AW-1:0]  wp [NCH];
  logic [AW-1:0]  wp_cur;
  logic [RAW-1:0] raddr;
  logic [RAW-1:0] waddr;
  logic           ram_we;
  logic           ram_re;
  logic [RAW-1:0] ram_waddr;
  logic [DW-1:0]  ram_wdata;
  logic [DW-1:0]  ram_rdata;
  logic           s1_valid;
  logic           s1_byp;
  logic [CHW-1:0] s1_ch;
  logic [DW-1:0]  s1_data;

  // The whole pipeline advances together whenever the output slot can move.
  assign en       = !out_valid || out_ready;
  assign in_ready = en && !busy;
  assign acc      = in_valid && in_ready;
  assign wp_cur   = wp[in_ch];
  assign byp      = (in_len == '0);
  assign raddr    = RAW'(make_addr(32'(in_ch), 32'(wp_cur - in_len), AW));
  assign waddr    = RAW'(make_addr(32'(in_ch), 32'(wp_cur), AW));

`ifdef DL_CLEAR_EN
  localparam logic [RAW-1:0] SWEEP_LAST = '1;

  clr_state_t state;
  clr_state_t state_nxt;

  // Clear FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLR_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A clr pulse always (re)starts the sweep; the sweep ends after the last word.
  always_comb begin
    state_nxt = state;
    case (state)
      CLR_IDLE:  if (clr) state_nxt = CLR_SWEEP;
      CLR_SWEEP: if (!clr && (sweep == SWEEP_LAST)) state_nxt = CLR_IDLE;
      default:   state_nxt = CLR_IDLE;
    endcase
  end

  // Clear FSM outputs.
  always_comb begin
    busy = (state == CLR_SWEEP);
  end

  // Sweep address restarts at 0 on every clr so a repeated clr covers everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sweep <= '0;
    end else if (clr) begin
      sweep <= '0;
    end else if (busy) begin
      sweep <= sweep + 1'b1;
    end
  end

  assign wipe = clr;
`else
  assign busy  = 1'b0;
  assign wipe  = 1'b0;
  assign sweep = '0;
`endif

  // Per-channel write pointers; they wrap naturally at 2**AW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) wp[i] <= '0;
    end else if (wipe) begin
      for (int i = 0; i < NCH; i++) wp[i] <= '0;
    end else if (acc) begin
      wp[in_ch] <= wp_cur + 1'b1;
    end
  end

  // The clear sweep owns the write port while busy; no samples are accepted then.
  // A bypass access skips the RAM read, so raddr == waddr never reaches it.
  assign ram_we    = acc || busy;
  assign ram_waddr = busy ? sweep : waddr;
  assign ram_wdata = busy ? '0 : in_data;
  assign ram_re    = en && !(acc && byp);

  dwg_sdp_ram #(
    .DW(DW),
    .AW(RAW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re   (ram_re),
    .raddr(raddr),
    .rdata(ram_rdata)
  );

  // Stage 1 travels alongside the registered RAM read and remembers bypass data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_ch    <= '0;
      s1_byp   <= 1'b0;
      s1_data  <= '0;
    end else if (en) begin
      s1_valid <= acc;
      s1_ch    <= in_ch;
      s1_byp   <= byp;
      s1_data  <= in_data;
    end
  end

  // Output register: picks the RAM word or the bypassed sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_ch   <= s1_ch;
        out_data <= s1_byp ? s1_data : ram_rdata;
      end
    end
  end

endmodule
